alu_sync: RTL and testbench
===========================

Name: alu_sync

Overview:
- Parameterised registered ALU: 4 arithmetic and 4 logic operations on two WIDTH-bit operands with carry-in.
- Selection is by a logic/arithmetic flag and a 2-bit opcode.
- Result and flags (zero, carry, sign) are registered on the clock edge with one cycle of latency.
- Sits in the datapath as the execution unit fed by the register file and operand muxes.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in, used by arithmetic ops only.
- Op  input  2  operation select.
- l  input  1  0 = arithmetic group, 1 = logic group.
- R  output  WIDTH  registered result.
- z  output  1  registered zero flag.
- c  output  1  registered carry flag.
- s  output  1  registered sign flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: at the rising clk edge with rst=1, outputs go to R=0, z=1, c=0, s=0. Reset has priority over the operation loaded that cycle.
- Latency: inputs sampled at rising edge N; R/z/c/s reflect them after edge N and hold until the next edge. No handshake; a new operation is accepted every cycle.
- Arithmetic (l=0): internal sum is WIDTH+1 bits, with operands zero-extended.
  - Op=00: A + cin (increment when cin=1).
  - Op=01: (~A) + 1 + cin (two's-complement negate of A, plus cin).
  - Op=10: A + B + cin.
  - Op=11: (~B) + 1 + cin (two's-complement negate of B, plus cin).
- Flags, arithmetic: R = sum[WIDTH-1:0], c = sum[WIDTH], s = R[WIDTH-1], z = (R == 0).
- Wrap-around: sums exceeding 2^WIDTH-1 wrap in R with c=1.
- Negate of 0 yields R=0, c=1 (e.g. Op=01, A=0, cin=0 → 16 → R=0000, c=1).
- Logic (l=1): cin is ignored.
  - Op=00: A & B.
  - Op=01: A | B.
  - Op=10: A ^ B.
  - Op=11: ~A.
- Flags, logic: c = 0, s = R[WIDTH-1], z = (R == 0).
- No X propagation: all 8 l/Op combinations are defined; no illegal encodings.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: adds output port v (1 bit, registered, reset 0). v is signed two's-complement overflow of the arithmetic op, i.e. the carry into the MSB XOR the carry out of the MSB of the WIDTH+1-bit sum. v is forced to 0 for logic ops.
- Not defined: no v port and no overflow logic; all other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for one edge with arbitrary inputs → R=0000, z=1, c=0, s=0. Deassert rst with l=0, Op=10, A=3, B=4, cin=0 → after next edge R=0111, z=0, c=0, s=0.
- Add wrap: l=0, Op=10, A=1111, B=0001, cin=0 → R=0000, z=1, c=1, s=0. Same with cin=1 and A=B=1111 → R=1111, c=1, s=1, z=0.
- Negate/increment: l=0, Op=01, A=0000, cin=0 → R=0000, c=1, z=1. Op=11, B=0011, cin=0 → R=1101, c=0, s=1. Op=00, A=0111, cin=1 → R=1000, s=1, c=0.
- Logic: l=1, A=1100, B=1010.
  - Op=00 → R=1000, s=1.
  - Op=01 → R=1110.
  - Op=10 → R=0110, s=0.
  - Op=11 → R=0011.
  - c=0 in every case; cin=1 has no effect.
- Exhaustive sweep: all l, Op, cin, A, B (2048 vectors, WIDTH=4), one per cycle. Compare each result one cycle later against the reference model above.
- Reset mid-stream: during the sweep, assert rst for one cycle → outputs return to reset values on that edge, and the vector presented that cycle is discarded.

Source files
------------

// File: rtl/alu_sync.sv
// alu_sync -- registered ALU, one cycle of latency, a new operation every cycle.
//
// Parameters:
//   WIDTH  operand/result width in bits (minimum 2)
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset (R=0, z=1, c=0, s=0)
//   A    in   operand A [WIDTH]
//   B    in   operand B [WIDTH]
//   cin  in   carry-in, arithmetic group only
//   Op   in   operation select [2]
//   l    in   0 = arithmetic group, 1 = logic group
//   R    out  registered result [WIDTH]
//   z    out  registered zero flag
//   c    out  registered carry flag (always 0 for logic ops)
//   s    out  registered sign flag (MSB of R)
//   v    out  registered signed overflow, present only with ALU_OVF_EN defined
//
// Optional feature macro: ALU_OVF_EN (adds the v port and overflow logic).

module alu_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [1:0]       Op,
  input  logic             l,
  output logic [WIDTH-1:0] R,
  output logic             z,
  output logic             c,
  output logic             s
`ifdef ALU_OVF_EN
  ,
  output logic             v
`endif
);

  // Every arithmetic op is expressed as add_x + add_y + add_k, where add_k
  // (0..2) folds the two's-complement "+1" of a negate together with cin.
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [1:0]       add_k;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_r;
  logic [WIDTH-1:0] next_r;
  logic             next_c;

  always_comb begin
    add_x = A;
    add_y = '0;
    add_k = {1'b0, cin};
    case (Op)
      2'b00: begin
        add_x = A;
      end
      2'b01: begin
        add_x = ~A;
        add_k = {1'b0, cin} + 2'd1;
      end
      2'b10: begin
        add_x = A;
        add_y = B;
      end
      default: begin
        add_x = ~B;
        add_k = {1'b0, cin} + 2'd1;
      end
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_k);

  always_comb begin
    logic_r = '0;
    case (Op)
      2'b00:   logic_r = A & B;
      2'b01:   logic_r = A | B;
      2'b10:   logic_r = A ^ B;
      default: logic_r = ~A;
    endcase
  end

  assign next_r = l ? logic_r : sum[WIDTH-1:0];
  assign next_c = ~l & sum[WIDTH];

`ifdef ALU_OVF_EN
  // Sum of the low WIDTH-1 bits; its top bit is the carry into the MSB.
  logic [WIDTH-1:0] low_sum;
  logic             next_v;

  assign low_sum = {1'b0, add_x[WIDTH-2:0]} + {1'b0, add_y[WIDTH-2:0]}
                 + WIDTH'(add_k);
  assign next_v  = ~l & (low_sum[WIDTH-1] ^ sum[WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
    end else begin
      v <= next_v;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      z <= 1'b1;
      c <= 1'b0;
      s <= 1'b0;
    end else begin
      R <= next_r;
      z <= (next_r == '0);
      c <= next_c;
      s <= next_r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_sync.sv
// tb_alu_sync -- scoreboard bench for alu_sync (WIDTH=4).
// Stimulus drives one vector per falling edge and queues the expected
// registered response; the monitor pops and compares after each rising edge.

module tb_alu_sync;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic [1:0]   op;
  logic         l_sel;
  logic [W-1:0] r_out;
  logic         z_out;
  logic         c_out;
  logic         s_out;
  logic         v_out;

  alu_sync #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .B   (b_in),
    .cin (cin),
    .Op  (op),
    .l   (l_sel),
    .R   (r_out),
    .z   (z_out),
    .c   (c_out),
    .s   (s_out)
`ifdef ALU_OVF_EN
    ,
    .v   (v_out)
`endif
  );

`ifndef ALU_OVF_EN
  assign v_out = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         s;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   done   = 1'b0;

  // Independent integer reference: negate is 2^W - x + cin.
  function automatic exp_t model(input logic lm, input logic [1:0] om,
                                 input logic [W-1:0] am, input logic [W-1:0] bm,
                                 input logic cm);
    exp_t e;
    int   sum;
    int   cin_msb;
    int   ai = int'(am);
    int   bi = int'(bm);
    int   ci = int'(cm);
    e.name = "sweep";
    e.v    = 1'b0;
    if (lm) begin
      case (om)
        2'b00:   e.r = am & bm;
        2'b01:   e.r = am | bm;
        2'b10:   e.r = am ^ bm;
        default: e.r = ~am;
      endcase
      e.c = 1'b0;
    end else begin
      case (om)
        2'b00: begin sum = ai + ci;           cin_msb = ((ai % 8) + ci) / 8; end
        2'b01: begin sum = 16 - ai + ci;      cin_msb = ((7 - (ai % 8)) + 1 + ci) / 8; end
        2'b10: begin sum = ai + bi + ci;      cin_msb = ((ai % 8) + (bi % 8) + ci) / 8; end
        default: begin sum = 16 - bi + ci;    cin_msb = ((7 - (bi % 8)) + 1 + ci) / 8; end
      endcase
      e.r = W'(sum % 16);
      e.c = (sum >= 16);
`ifdef ALU_OVF_EN
      e.v = ((cin_msb != 0) != (sum >= 16));
`endif
    end
    e.z = (e.r == '0);
    e.s = e.r[W-1];
    return e;
  endfunction

  task automatic issue(input logic rs, input logic li, input logic [1:0] oi,
                       input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input exp_t e);
    @(negedge clk);
    rst   = rs;
    l_sel = li;
    op    = oi;
    a_in  = ai;
    b_in  = bi;
    cin   = ci;
    exp_q.push_back(e);
  endtask

  function automatic exp_t mk(input string n, input logic [W-1:0] r,
                              input logic zz, input logic cc, input logic ss,
                              input logic vv);
    exp_t e;
    e.name = n; e.r = r; e.z = zz; e.c = cc; e.s = ss;
`ifdef ALU_OVF_EN
    e.v = vv;
`else
    e.v = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: one registered result per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (r_out !== e.r || z_out !== e.z || c_out !== e.c ||
            s_out !== e.s || v_out !== e.v) begin
          fails++;
          $display("FAIL %s: got R=%b z=%b c=%b s=%b v=%b, expected R=%b z=%b c=%b s=%b v=%b",
                   e.name, r_out, z_out, c_out, s_out, v_out,
                   e.r, e.z, e.c, e.s, e.v);
        end
      end
    end
  end

  initial begin
    exp_t rst_e;
    int   n;
    rst_e = mk("reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset applied before the first rising edge, arbitrary operands.
    rst = 1'b1; l_sel = 1'b0; op = 2'b10; a_in = 4'hF; b_in = 4'h5; cin = 1'b1;
    exp_q.push_back(rst_e);

    issue(0, 0, 2'b10, 4'd3,     4'd4,     0, mk("add_3_4",      4'b0111, 0, 0, 0, 0));
    issue(0, 0, 2'b10, 4'b1111,  4'b0001,  0, mk("add_wrap",     4'b0000, 1, 1, 0, 0));
    issue(0, 0, 2'b10, 4'b1111,  4'b1111,  1, mk("add_wrap_cin", 4'b1111, 0, 1, 1, 0));
    issue(0, 0, 2'b01, 4'b0000,  4'b1010,  0, mk("neg_a_zero",   4'b0000, 1, 1, 0, 0));
    issue(0, 0, 2'b11, 4'b0110,  4'b0011,  0, mk("neg_b_3",      4'b1101, 0, 0, 1, 0));
    issue(0, 0, 2'b00, 4'b0111,  4'b1001,  1, mk("inc_7",        4'b1000, 0, 0, 1, 1));
    issue(0, 1, 2'b00, 4'b1100,  4'b1010,  0, mk("and",          4'b1000, 0, 0, 1, 0));
    issue(0, 1, 2'b01, 4'b1100,  4'b1010,  0, mk("or",           4'b1110, 0, 0, 1, 0));
    issue(0, 1, 2'b10, 4'b1100,  4'b1010,  0, mk("xor",          4'b0110, 0, 0, 0, 0));
    issue(0, 1, 2'b11, 4'b1100,  4'b1010,  0, mk("not",          4'b0011, 0, 0, 0, 0));
    issue(0, 1, 2'b00, 4'b1100,  4'b1010,  1, mk("and_cin",      4'b1000, 0, 0, 1, 0));
    issue(0, 1, 2'b01, 4'b1100,  4'b1010,  1, mk("or_cin",       4'b1110, 0, 0, 1, 0));
    issue(0, 1, 2'b10, 4'b1100,  4'b1010,  1, mk("xor_cin",      4'b0110, 0, 0, 0, 0));
    issue(0, 1, 2'b11, 4'b1100,  4'b1010,  1, mk("not_cin",      4'b0011, 0, 0, 0, 0));

    // Exhaustive sweep; one vector is replaced by a mid-stream reset.
    n = 0;
    for (int li = 0; li < 2; li++)
      for (int oi = 0; oi < 4; oi++)
        for (int ci = 0; ci < 2; ci++)
          for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++) begin
              if (n == 1000)
                issue(1, li[0], oi[1:0], ai[3:0], bi[3:0], ci[0], rst_e);
              else
                issue(0, li[0], oi[1:0], ai[3:0], bi[3:0], ci[0],
                      model(li[0], oi[1:0], ai[3:0], bi[3:0], ci[0]));
              n++;
            end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
